// File: rtl/editor_pkg.sv
// Shared definitions for the editor input path: code width, line terminator,
// owner encoding and the line arbiter state set.
package editor_pkg;

  localparam int CODE_W     = 8;
  localparam int ENTER_CODE = 66;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'b00,
    OWN_KBD    = 2'b01,
    OWN_SCRIPT = 2'b10
  } owner_t;

  typedef enum logic {
    ST_GAP    = 1'b0,
    ST_STREAM = 1'b1
  } arb_state_t;

endpackage

// File: rtl/editor_char_fifo.sv
// Synchronous keyboard character FIFO; a push while full is honoured only when
// a pop happens in the same cycle.
module editor_char_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop_ok;
  logic         push_ok;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/editor_line_arbiter.sv
// Line-atomic scheduler sharing the editor ch_input between keyboard and boot script.
// Optional line-length limit enabled by defining EDITOR_ARB_LINE_LIMIT_EN.
module editor_line_arbiter #(
  parameter int CODE_W     = editor_pkg::CODE_W,
  parameter int ENTER_CODE = editor_pkg::ENTER_CODE,
  parameter int GAP_CYCLES = 255,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_LINE   = 63
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              kbd_valid,
  input  logic [CODE_W-1:0] kbd_ch,
  output logic              kbd_ready,
  output logic              kbd_overflow,
  input  logic              script_valid,
  input  logic [CODE_W-1:0] script_ch,
  output logic              script_ready,
  input  logic              busy,
  output logic [CODE_W-1:0] ch_out,
  output logic [1:0]        owner,
  output logic [15:0]       lines_done
);

  import editor_pkg::*;

  localparam logic [CODE_W-1:0] ENTER   = CODE_W'(ENTER_CODE);
  localparam logic [15:0]       GAP_MAX = 16'(GAP_CYCLES);

  arb_state_t        state;
  owner_t            owner_q;
  logic              rr_kbd;
  logic [15:0]       gap_cnt;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CODE_W-1:0] fifo_dout;

  logic              streaming;
  logic              limit_hit;
  logic              acc_valid;
  logic [CODE_W-1:0] acc_ch;
  logic              line_end;
  logic              kbd_pend;
  logic              grant;
  logic              grant_kbd;

  assign fifo_push = kbd_valid && (kbd_ch != '0);
  assign kbd_ready = !fifo_full;
  assign owner     = owner_q;

  editor_char_fifo #(
    .W     (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_kbd_fifo (
    .clk   (clk_25mhz),
    .rst_n (reset_n),
    .push  (fifo_push),
    .din   (kbd_ch),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every signal gets a default first so no path leaves a latch behind.
  always_comb begin
    streaming    = (state == ST_STREAM);
    script_ready = streaming && (owner_q == OWN_SCRIPT) && !limit_hit;
    fifo_pop     = streaming && (owner_q == OWN_KBD) && !fifo_empty && !limit_hit;
    acc_valid    = fifo_pop || (script_valid && script_ready);
    acc_ch       = (owner_q == OWN_KBD) ? fifo_dout : script_ch;
    line_end     = streaming && (limit_hit || (acc_valid && (acc_ch == ENTER)));
    kbd_pend     = !fifo_empty;
    grant        = (state == ST_GAP) && (gap_cnt == GAP_MAX) && !busy &&
                   (kbd_pend || script_valid);
    grant_kbd    = kbd_pend && (!script_valid || rr_kbd);
  end

`ifdef EDITOR_ARB_LINE_LIMIT_EN
  localparam int LINE_W = $clog2(MAX_LINE + 1);

  logic [LINE_W-1:0] line_cnt;

  assign limit_hit = streaming && (line_cnt == LINE_W'(MAX_LINE));

  // Only non-zero forwarded characters count toward the line length.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt <= '0;
    end else if (grant || line_end) begin
      line_cnt <= '0;
    end else if (streaming && acc_valid && (acc_ch != '0)) begin
      line_cnt <= line_cnt + 1'b1;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignment so every read sees pre-edge values.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_GAP;
      owner_q      <= OWN_NONE;
      rr_kbd       <= 1'b1;
      gap_cnt      <= '0;
      ch_out       <= '0;
      lines_done   <= '0;
      kbd_overflow <= 1'b0;
    end else begin
      kbd_overflow <= fifo_push && fifo_full && !fifo_pop;
      ch_out       <= '0;
      if (state == ST_GAP) begin
        if (busy) begin
          gap_cnt <= '0;
        end else if (gap_cnt != GAP_MAX) begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        if (grant) begin
          state   <= ST_STREAM;
          owner_q <= grant_kbd ? OWN_KBD : OWN_SCRIPT;
          // The pointer only moves when it actually arbitrated a collision.
          if (kbd_pend && script_valid) rr_kbd <= !rr_kbd;
        end
      end else begin
        if (line_end) begin
          ch_out     <= ENTER;
          lines_done <= lines_done + 1'b1;
          owner_q    <= OWN_NONE;
          state      <= ST_GAP;
          gap_cnt    <= '0;
        end else if (acc_valid) begin
          ch_out <= acc_ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_editor_line_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the line arbitration rules.
module tb_editor_line_arbiter;

  localparam int GAP   = 4;
  localparam int DEPTH = 8;
  localparam int MAXL  = 3;
  localparam int ENTER = 66;

  logic        clk_25mhz = 1'b0;
  logic        reset_n   = 1'b0;
  logic        kbd_valid = 1'b0;
  logic [7:0]  kbd_ch    = '0;
  logic        kbd_ready;
  logic        kbd_overflow;
  logic        script_valid = 1'b0;
  logic [7:0]  script_ch    = '0;
  logic        script_ready;
  logic        busy = 1'b0;
  logic [7:0]  ch_out;
  logic [1:0]  owner;
  logic [15:0] lines_done;

  editor_line_arbiter #(
    .CODE_W     (8),
    .ENTER_CODE (ENTER),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (DEPTH),
    .MAX_LINE   (MAXL)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .reset_n      (reset_n),
    .kbd_valid    (kbd_valid),
    .kbd_ch       (kbd_ch),
    .kbd_ready    (kbd_ready),
    .kbd_overflow (kbd_overflow),
    .script_valid (script_valid),
    .script_ch    (script_ch),
    .script_ready (script_ready),
    .busy         (busy),
    .ch_out       (ch_out),
    .owner        (owner),
    .lines_done   (lines_done)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending characters live in queues, the gap is a run length
  // of idle cycles, ownership is a plain integer (0 none, 1 keyboard, 2 script).
  logic [7:0] kq[$];
  logic [7:0] sq[$];
  bit m_stream;
  int m_owner;
  bit m_rr_kbd;
  int m_idle;
  int m_line;
  int m_ch;
  bit m_ovf;
  int m_lines;

  function automatic bit m_limit();
`ifdef EDITOR_ARB_LINE_LIMIT_EN
    return m_stream && (m_line == MAXL);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    kq.delete();
    m_stream = 0; m_owner = 0; m_rr_kbd = 1; m_idle = 0;
    m_line = 0; m_ch = 0; m_ovf = 0; m_lines = 0;
  endtask

  task automatic model_step(input bit kv, input logic [7:0] kch, input bit sv, input bit bz);
    int         old_kn = kq.size();
    bit         popped = 0;
    bit         got    = 0;
    bit         ended  = 0;
    logic [7:0] c      = '0;
    int         n_ch   = 0;
    if (!m_stream) begin
      m_idle = bz ? 0 : ((m_idle < 1000) ? m_idle + 1 : m_idle);
      // A grant needs GAP idle cycles already seen plus an idle current cycle.
      if (!bz && m_idle >= GAP + 1 && (old_kn > 0 || sv)) begin
        if (old_kn > 0 && sv) begin
          m_owner  = m_rr_kbd ? 1 : 2;
          m_rr_kbd = !m_rr_kbd;
        end else begin
          m_owner = (old_kn > 0) ? 1 : 2;
        end
        m_stream = 1;
        m_line   = 0;
      end
    end else if (m_limit()) begin
      ended = 1;
    end else begin
      if (m_owner == 1 && old_kn > 0) begin
        c = kq.pop_front(); popped = 1; got = 1;
      end else if (m_owner == 2 && sv) begin
        c = sq.pop_front(); got = 1;
      end
      if (got) begin
        if (c == 8'(ENTER)) ended = 1;
        else begin
          n_ch = c;
          if (c != 0) m_line++;
        end
      end
    end
    if (ended) begin
      n_ch     = ENTER;
      m_lines  = (m_lines + 1) & 16'hFFFF;
      m_owner  = 0;
      m_stream = 0;
      m_idle   = 0;
    end
    m_ovf = 0;
    if (kv && kch != 0) begin
      if (old_kn < DEPTH || popped) kq.push_back(kch);
      else m_ovf = 1;
    end
    m_ch = n_ch;
  endtask

  // One clock cycle: drive inputs away from the edge, check combinational
  // outputs, advance the model, then check registered outputs after the edge.
  task automatic apply(input bit kv, input logic [7:0] kch, input bit sv, input bit bz);
    kbd_valid    = kv;
    kbd_ch       = kch;
    script_valid = sv && (sq.size() > 0);
    script_ch    = (sq.size() > 0) ? sq[0] : 8'd0;
    busy         = bz;
    #1;
    check("kbd_ready", kbd_ready, kq.size() < DEPTH);
    check("script_ready", script_ready, m_stream && m_owner == 2 && !m_limit());
    model_step(kv, kch, script_valid, bz);
    @(posedge clk_25mhz);
    #1;
    check("ch_out", ch_out, m_ch);
    check("owner", owner, m_owner);
    check("lines_done", lines_done, m_lines);
    check("kbd_overflow", kbd_overflow, m_ovf);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ch_out"}, ch_out, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_lines_done"}, lines_done, 0);
    check({tag, "_kbd_overflow"}, kbd_overflow, 0);
  endtask

  function automatic logic [7:0] rand_ch();
    int r = $urandom_range(0, 9);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'(ENTER);
    return 8'($urandom_range(1, 255));
  endfunction

  initial begin
    model_reset();
    sq.delete();
    #50;
    check_reset_values("reset");
    check("reset_kbd_ready", kbd_ready, 1);
    check("reset_script_ready", script_ready, 0);
    @(negedge clk_25mhz);
    reset_n = 1'b1;

    // Script-only line, then a line containing a zero code.
    sq = '{8'd53, 8'd9, 8'd4, 8'd66};
    repeat (16) apply(0, 8'd0, 1, 0);
    sq = '{8'd1, 8'd0, 8'd2, 8'd66};
    repeat (16) apply(0, 8'd0, 1, 0);

    // Fill the FIFO while the editor is busy, overflow once, then drain
    // while pushing into a full FIFO alongside pops.
    for (int i = 0; i < 9; i++) apply(1, 8'(10 + i), 0, 1);
    repeat (3) apply(0, 8'd0, 0, 1);
    for (int i = 0; i < 12; i++) apply(1, 8'(30 + i), 0, 0);
    apply(1, 8'(ENTER), 0, 0);
    repeat (20) apply(0, 8'd0, 0, 0);

    // Both sources pending at gap expiry: lines alternate starting with the pointer.
    sq = '{8'd5, 8'd6, 8'd66, 8'd7, 8'd66};
    apply(1, 8'd20, 0, 1);
    apply(1, 8'd21, 0, 1);
    apply(1, 8'(ENTER), 0, 1);
    apply(1, 8'd40, 0, 1);
    apply(1, 8'(ENTER), 0, 1);
    repeat (40) apply(0, 8'd0, 1, 0);

    // Busy pulse a few cycles into the gap restarts the idle count.
    sq = '{8'd3, 8'd66};
    repeat (3) apply(0, 8'd0, 1, 0);
    apply(0, 8'd0, 1, 1);
    repeat (12) apply(0, 8'd0, 1, 0);

    // Randomized traffic with an asynchronous reset pulse in the middle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (sq.size() < 4) begin
        int len = $urandom_range(0, 6);
        for (int j = 0; j < len; j++) begin
          logic [7:0] c = rand_ch();
          sq.push_back((c == 8'(ENTER)) ? 8'd1 : c);
        end
        sq.push_back(8'(ENTER));
      end
      apply($urandom_range(0, 9) < 4, rand_ch(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0);
      if (cyc == 1500) begin
        #1 reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(negedge clk_25mhz);
        reset_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/editor_line_arbiter.md
# editor_line_arbiter

Line-atomic input scheduler in front of `model_editor`'s `ch_input` port, sharing it between a keyboard source (buffered in a small FIFO) and a boot-script source (pull handshake). Once a source is granted, it owns the editor for a whole line, terminated by the enter code. After each line, the arbiter waits for the editor to go idle and stay idle for a guard gap before granting the next line. Sits between the keyboard decoder / script ROM and the editor, in the `clk_25mhz` domain.

## Interface
- `CODE_W`, 8: character code width; code 0 means "no character".
- `ENTER_CODE`, 66: line terminator code.
- `GAP_CYCLES`, 255: consecutive editor-idle cycles required before a new grant (1..65535).
- `FIFO_DEPTH`, 8: keyboard FIFO entries (power of two, ≥2).
- `MAX_LINE`, 63: line-length limit; used only with the limit feature.

Ports:
- `clk_25mhz`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `kbd_valid`  in  1  keyboard character strobe.
- `kbd_ch`  in  CODE_W  keyboard character.
- `kbd_ready`  out  1  FIFO not full.
- `kbd_overflow`  out  1  one-cycle pulse when a keyboard char is dropped.
- `script_valid`  in  1  script character available.
- `script_ch`  in  CODE_W  script character.
- `script_ready`  out  1  script char accepted when high with `script_valid`.
- `busy`  in  1  editor busy (`cmd[0]`).
- `ch_out`  out  CODE_W  drives editor `ch_input`; registered.
- `owner`  out  2  00 none, 01 keyboard, 10 script.
- `lines_done`  out  16  completed-line counter; wraps at 0xFFFF→0.

## Operation
- Reset: `ch_out`=0, `owner`=00, `kbd_overflow`=0, `lines_done`=0, FIFO empty, gap counter 0, state GAP, round-robin pointer = keyboard-first.
- Keyboard push: on `kbd_valid` with `kbd_ch`≠0. If full and no pop that cycle, the char is dropped and `kbd_overflow` pulses. Full with a simultaneous pop: the push is accepted.
- **GAP**: the counter increments while `busy`=0 and clears to 0 on any cycle with `busy`=1. Saturates at `GAP_CYCLES`.
- At saturation, if the FIFO is non-empty and/or `script_valid`=1, go to STREAM and grant:
  - Only one source pending: grant it.
  - Both pending: grant the round-robin pointer's source, then flip the pointer to the other source.
  - Neither pending: stay in GAP, saturated.
- **STREAM**:
  - The owner's head char is accepted in any cycle it is available: FIFO non-empty, or `script_valid`&&`script_ready`.
  - Accepted char ≠0: forwarded to `ch_out` the next cycle.
  - Accepted char =0: consumed and discarded; `ch_out` is 0 the next cycle.
  - No char available: `ch_out` is 0 the next cycle; ownership is held.
  - Accepting `ENTER_CODE` ends the line: the next cycle `ch_out`=`ENTER_CODE`, then 0. `lines_done` increments, `owner` goes to 00, the state returns to GAP with the counter cleared.
- `script_ready` = (state STREAM) && (owner = script); combinational.
- `busy` is ignored during STREAM.

## Timing
- Accept → `ch_out` latency: 1 cycle.
- Throughput: 1 char per cycle.
- Minimum gap between an ENTER on `ch_out` and the first char of the next line: `GAP_CYCLES`+1 cycles, assuming the editor stays idle.
- `owner` changes on the grant edge.
- The first char is accepted on the same edge as the grant at the earliest, so it appears on `ch_out` one cycle after `owner` changes.
- `reset_n` low mid-line: everything returns to reset values immediately; FIFO contents are lost; the partial line is not terminated.

## Configuration
- `EDITOR_ARB_LINE_LIMIT_EN` defined:
  - The line char count includes non-zero forwarded chars only.
  - If `MAX_LINE` chars are forwarded without an ENTER, the arbiter injects `ENTER_CODE` on `ch_out` in the next cycle, accepting no source char that cycle, and ends the line normally.
  - The source's remaining chars compete for a later line.
- Undefined: no count; line length is unbounded.

## Structure
- Shared package `editor_pkg`: `CODE_W`, `ENTER_CODE`, the `owner_t` encoding, and the arbiter state enum (GAP, STREAM).
- One sub-module: `editor_char_fifo`, a synchronous FIFO with push/pop/full/empty and async active-low clear, used for the keyboard path.

## Test plan
- Script only, chars 53,9,4,66 at `GAP_CYCLES`=4, `busy`=0 → `ch_out` shows 53,9,4,66,0; `owner` is 10 for 4 accepts; `lines_done`=1; next grant no earlier than 5 cycles later.
- Both sources pending at gap expiry → keyboard line first, script line next, keyboard line after that; no interleaving of chars between lines.
- `busy` pulses high 3 cycles into the gap → the counter restarts, and the grant is delayed by the full `GAP_CYCLES` after `busy` falls.
- Fill the FIFO (8 chars), push a 9th with no pop → `kbd_overflow` pulses once and the 9th char never appears. Push while full with a simultaneous pop → accepted.
- Script sends 1,0,2,66 → `ch_out` shows 1,0,2,66; the zero is consumed without stalling.
- With `EDITOR_ARB_LINE_LIMIT_EN`, `MAX_LINE`=3, script sends 1,2,3,4,66 → `ch_out` shows 1,2,3,66 with `lines_done`=1; then, after the gap, 4,66 with `lines_done`=2.
- `reset_n` pulsed low mid-line → `ch_out`, `owner`, and `lines_done` are 0 within the same cycle.
